bumpy_motion: RTL and testbench
===============================

Name: bumpy_motion

Overview:
Downstream of the Bumpy state FSM. Consumes the FSM's 4-bit state plus the raw bottom-collision signals, and produces Bumpy's on-screen top-left position once per video frame. It uses fixed-point velocity and gravity integration. It also runs the death-freeze timer and signals its expiry to the life counter.

Parameters:
INIT_X, 280, reset/Sreset X position (pixels)
INIT_Y, 100, reset/Sreset Y position (pixels)
X_SPEED, 64, horizontal speed magnitude (pixels*64 per frame)
JUMP_SPEED, 256, normal bounce launch magnitude (pixels*64 per frame)
UP_JUMP_SPEED, 384, Sup launch magnitude
Y_ACCEL, 8, gravity added to Y speed each frame
MAX_Y_SPEED, 512, clamp on downward Y speed
DIE_FRAMES, 60, frames frozen in Sdie before die_done
OBJ_W / OBJ_H, 32 / 32, sprite size (pixels)
SCREEN_W / SCREEN_H, 640 / 480, visible area (pixels)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame
state  in  4  FSM present state (bumpy_pkg encoding)
bumpy_collision  in  1  Bumpy pixel overlaps a tile
HitEdgeCode  in  4  {Left,Top,Right,Bottom} edge of the hit
topLeftX  out  11 signed  sprite X (pixels)
topLeftY  out  11 signed  sprite Y (pixels)
die_done  out  1  one-cycle pulse when the death freeze expires

Behaviour:
- Reset is asynchronous and active-high. It sets posX=INIT_X*64, posY=INIT_Y*64, Xspeed=Yspeed=0, prevState=Sreset, land_flag=0, die_cnt=0, die_done=0. Outputs show INIT_X/INIT_Y immediately, with no clock edge needed.
- land_flag is set in any cycle where bumpy_collision && HitEdgeCode==4'b0001. It clears on startOfFrame. A landing in the startOfFrame cycle itself counts for that frame: land_eff = land_flag | current landing.
- All motion updates happen only in startOfFrame cycles. Between pulses, every register holds except land_flag.
- launch = (state != prevState) || land_eff. prevState <= state on every startOfFrame.
- If launch, the velocities are loaded per state:
  - Sidle: X=0, Y=-JUMP
  - Sleft: X=-X_SPEED, Y=-JUMP
  - Sright: X=+X_SPEED, Y=-JUMP
  - Sup: X=0, Y=-UP_JUMP_SPEED
  - Sdown: X=0, Y=0
  - Sbounce_from_left: X=+X_SPEED, Y=-(JUMP>>>1)
  - Sbounce_from_right: X=-X_SPEED, Y=-(JUMP>>>1)
  - Sbounce_from_top: X=0, Y=+(JUMP>>>1)
- If no launch (motion states only): Yspeed = min(Yspeed+Y_ACCEL, MAX_Y_SPEED). Xspeed holds. No gravity is applied in a launch frame.
- Sreset, every frame: pos=INIT, speeds=0.
- Sdie or an unused encoding: speeds=0, pos holds.
- Position update uses the speed computed in the same frame: pos += newSpeed.
- Position clamps:
  - X is clamped to [0,(SCREEN_W-OBJ_W)*64]. If it clamps, Xspeed is forced to 0.
  - Y is clamped to [0,(SCREEN_H-OBJ_H)*64]. If it clamps, Yspeed is forced to 0.
- Widths: pos is 18-bit signed and speed is 11-bit signed. Sign-extend before adding. Saturating clamp only, never wrap.
- topLeftX = posX>>>6 and topLeftY = posY>>>6, driven combinationally from the registers. Latency is 1 cycle after startOfFrame.
- Death timer:
  - In Sdie, on each startOfFrame, die_cnt increments while die_cnt < DIE_FRAMES.
  - die_done=1 for exactly the startOfFrame cycle in which die_cnt reaches DIE_FRAMES. The counter then saturates, so there is no repeat pulse.
  - Any startOfFrame with state != Sdie clears die_cnt.
- Simultaneous state change and landing: a single launch, using the new state's table entry.
- Reset mid-frame or mid-death aborts everything: outputs return to INIT and die_cnt returns to 0.

Decomposition:
- bumpy_pkg holds:
  - the state enum: Sreset=0, Sidle, Sleft, Sright, Sdown, Sup, Sdie, Sbounce_from_left, Sbounce_from_right, Sbounce_from_top=9. This is shared with the FSM, replacing its local enum.
  - edge constants: BOTTOM=0001, RIGHT=0010, TOP=0100, LEFT=1000.
  - tile type constants: FREE, REGU, GATE, DEATH, WALL.
  - FIXED_POINT_MULTIPLIER=64.
- One sub-module is natural: bumpy_die_timer, a frame counter that generates the die_done pulse. Everything else stays in bumpy_motion.

Test Plan:
- Async reset asserted with no clock -> topLeftX=280, topLeftY=100, die_done=0 within the same cycle.
- state Sreset->Sright, one startOfFrame -> Xspeed=64, Yspeed=-256, topLeftX=281, topLeftY=96. Next frame (no landing) -> Yspeed=-248, topLeftX=282, topLeftY=92.
- In Sleft, mid-frame pulse of bumpy_collision with HitEdgeCode=0001 -> at next startOfFrame Yspeed reloads to -256 and land_flag clears. A following frame without collision -> gravity applies (-248).
- In Sleft with topLeftX=1 -> after frame 1 X=0. Frame 2 clamps at X=0 with Xspeed=0. Also drive Y downward until Y=448 -> Y holds at 448 and Yspeed=0.
- DIE_FRAMES=4, enter Sdie -> position frozen. die_done pulses exactly once, for one cycle, on the 4th startOfFrame. No pulse on the 5th-8th frames.
- Sdie at die_cnt=2, then state->Sidle and back to Sdie -> counter restarts, and die_done occurs 4 frames after re-entry.

Source files
------------

// File: rtl/bumpy_pkg.sv
// Shared definitions for Bumpy: FSM state encoding, tile-edge codes, tile
// types and the fixed-point scale used by the motion datapath.
package bumpy_pkg;

  typedef enum logic [3:0] {
    Sreset             = 4'd0,
    Sidle              = 4'd1,
    Sleft              = 4'd2,
    Sright             = 4'd3,
    Sdown              = 4'd4,
    Sup                = 4'd5,
    Sdie               = 4'd6,
    Sbounce_from_left  = 4'd7,
    Sbounce_from_right = 4'd8,
    Sbounce_from_top   = 4'd9
  } bumpy_state_e;

  // HitEdgeCode bit order is {Left,Top,Right,Bottom}
  typedef enum logic [3:0] {
    BOTTOM = 4'b0001,
    RIGHT  = 4'b0010,
    TOP    = 4'b0100,
    LEFT   = 4'b1000
  } hit_edge_e;

  typedef enum logic [2:0] {
    FREE  = 3'd0,
    REGU  = 3'd1,
    GATE  = 3'd2,
    DEATH = 3'd3,
    WALL  = 3'd4
  } tile_e;

  localparam int FIXED_POINT_MULTIPLIER = 64;

endpackage

// File: rtl/bumpy_motion_if.sv
// Frame-rate control inputs and sprite-position outputs of the Bumpy motion block.
interface bumpy_motion_if;
  logic               startOfFrame;
  logic [3:0]         state;
  logic               bumpy_collision;
  logic [3:0]         HitEdgeCode;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               die_done;

  modport master (
    output startOfFrame, state, bumpy_collision, HitEdgeCode,
    input  topLeftX, topLeftY, die_done
  );

  modport slave (
    input  startOfFrame, state, bumpy_collision, HitEdgeCode,
    output topLeftX, topLeftY, die_done
  );
endinterface

// File: rtl/bumpy_die_timer.sv
// Counts frames spent in the death state and pulses die_done_o once when
// the freeze period expires; the count saturates so the pulse never repeats.
module bumpy_die_timer #(
  parameter int DIE_FRAMES = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic sof_i,
  input  logic in_die_i,
  output logic die_done_o
);

  localparam int            CW    = $clog2(DIE_FRAMES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DIE_FRAMES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (sof_i) begin
      if (!in_die_i) begin
        cnt_d = '0;
      end else if (cnt_q < LIMIT) begin
        cnt_d  = cnt_q + CW'(1);
        done_d = (cnt_d == LIMIT);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign die_done_o = done_q;

endmodule

// File: rtl/bumpy_motion.sv
// Per-frame fixed-point integration of Bumpy's velocity and position, driven
// by the FSM state and bottom landings, plus the death-freeze timer.
module bumpy_motion
  import bumpy_pkg::*;
#(
  parameter int INIT_X        = 280,
  parameter int INIT_Y        = 100,
  parameter int X_SPEED       = 64,
  parameter int JUMP_SPEED    = 256,
  parameter int UP_JUMP_SPEED = 384,
  parameter int Y_ACCEL       = 8,
  parameter int MAX_Y_SPEED   = 512,
  parameter int DIE_FRAMES    = 60,
  parameter int OBJ_W         = 32,
  parameter int OBJ_H         = 32,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480
) (
  input  logic          clk,
  input  logic          reset,
  bumpy_motion_if.slave bus
);

  localparam int                 FP       = FIXED_POINT_MULTIPLIER;
  localparam logic signed [17:0] INIT_XFP = 18'(INIT_X * FP);
  localparam logic signed [17:0] INIT_YFP = 18'(INIT_Y * FP);
  localparam logic signed [18:0] X_MAX    = 19'((SCREEN_W - OBJ_W) * FP);
  localparam logic signed [18:0] Y_MAX    = 19'((SCREEN_H - OBJ_H) * FP);
  localparam logic signed [10:0] XS       = 11'(X_SPEED);
  localparam logic signed [10:0] JS       = 11'(JUMP_SPEED);
  localparam logic signed [10:0] HJS      = 11'(JUMP_SPEED / 2);
  localparam logic signed [10:0] UJS      = 11'(UP_JUMP_SPEED);
  localparam logic signed [11:0] YACC     = 12'(Y_ACCEL);
  localparam logic signed [11:0] YSPD_MAX = 12'(MAX_Y_SPEED);

  logic signed [17:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [10:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d;
  logic [3:0]         prev_q, prev_d;
  logic               land_q, land_d;

  logic               landing_s, launch_s;
  logic signed [11:0] grav_s;
  logic signed [10:0] nsx_s, nsy_s;
  logic signed [18:0] sum_x_s, sum_y_s;

  assign landing_s = bus.bumpy_collision && (bus.HitEdgeCode == BOTTOM);
  assign launch_s  = (bus.state != prev_q) || land_q || landing_s;
  assign grav_s    = {spd_y_q[10], spd_y_q} + YACC;

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    spd_x_d = spd_x_q;
    spd_y_d = spd_y_q;
    prev_d  = prev_q;
    nsx_s   = spd_x_q;
    nsy_s   = spd_y_q;
    sum_x_s = '0;
    sum_y_s = '0;
    land_d  = bus.startOfFrame ? 1'b0 : (land_q | landing_s);
    if (bus.startOfFrame) begin
      prev_d = bus.state;
      case (bus.state)
        Sreset: begin
          pos_x_d = INIT_XFP;
          pos_y_d = INIT_YFP;
          spd_x_d = '0;
          spd_y_d = '0;
        end
        Sidle, Sleft, Sright, Sdown, Sup,
        Sbounce_from_left, Sbounce_from_right, Sbounce_from_top: begin
          if (launch_s) begin
            case (bus.state)
              Sidle:              begin nsx_s = '0;  nsy_s = -JS;  end
              Sleft:              begin nsx_s = -XS; nsy_s = -JS;  end
              Sright:             begin nsx_s = XS;  nsy_s = -JS;  end
              Sup:                begin nsx_s = '0;  nsy_s = -UJS; end
              Sbounce_from_left:  begin nsx_s = XS;  nsy_s = -HJS; end
              Sbounce_from_right: begin nsx_s = -XS; nsy_s = -HJS; end
              Sbounce_from_top:   begin nsx_s = '0;  nsy_s = HJS;  end
              default:            begin nsx_s = '0;  nsy_s = '0;   end
            endcase
          end else begin
            nsx_s = spd_x_q;
            nsy_s = (grav_s > YSPD_MAX) ? YSPD_MAX[10:0] : grav_s[10:0];
          end
          // Saturate at the screen edges; hitting an edge kills that axis' speed
          sum_x_s = {pos_x_q[17], pos_x_q} + {{8{nsx_s[10]}}, nsx_s};
          sum_y_s = {pos_y_q[17], pos_y_q} + {{8{nsy_s[10]}}, nsy_s};
          if (sum_x_s < 19'sd0) begin
            pos_x_d = '0;
            spd_x_d = '0;
          end else if (sum_x_s > X_MAX) begin
            pos_x_d = X_MAX[17:0];
            spd_x_d = '0;
          end else begin
            pos_x_d = sum_x_s[17:0];
            spd_x_d = nsx_s;
          end
          if (sum_y_s < 19'sd0) begin
            pos_y_d = '0;
            spd_y_d = '0;
          end else if (sum_y_s > Y_MAX) begin
            pos_y_d = Y_MAX[17:0];
            spd_y_d = '0;
          end else begin
            pos_y_d = sum_y_s[17:0];
            spd_y_d = nsy_s;
          end
        end
        default: begin
          spd_x_d = '0;
          spd_y_d = '0;
        end
      endcase
    end else begin
      prev_d = prev_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x_q <= INIT_XFP;
      pos_y_q <= INIT_YFP;
      spd_x_q <= '0;
      spd_y_q <= '0;
      prev_q  <= Sreset;
      land_q  <= 1'b0;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      spd_x_q <= spd_x_d;
      spd_y_q <= spd_y_d;
      prev_q  <= prev_d;
      land_q  <= land_d;
    end
  end

  assign bus.topLeftX = pos_x_q[16:6];
  assign bus.topLeftY = pos_y_q[16:6];

  bumpy_die_timer #(
    .DIE_FRAMES(DIE_FRAMES)
  ) u_die_timer (
    .clk        (clk),
    .reset      (reset),
    .sof_i      (bus.startOfFrame),
    .in_die_i   (bus.state == Sdie),
    .die_done_o (bus.die_done)
  );

endmodule

// File: tb/tb_bumpy_motion.sv
// Randomized scoreboard bench for bumpy_motion against a frame-level pixel model.
module tb_bumpy_motion;

  localparam int DIE = 4;
  localparam int IX = 280, IY = 100;
  localparam int XMAXFP = (640 - 32) * 64;
  localparam int YMAXFP = (480 - 32) * 64;

  typedef struct {
    int x;
    int y;
    bit done;
  } exp_t;

  logic clk;
  logic reset;
  bumpy_motion_if bus ();

  bumpy_motion #(.DIE_FRAMES(DIE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  int   last_x = IX, last_y = IY;

  // Reference model state: fixed-point position and speed, frame-level rules
  int m_px, m_py, m_vx, m_vy, m_prev, m_cnt;
  bit m_land;

  function automatic void chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    m_px = IX * 64; m_py = IY * 64; m_vx = 0; m_vy = 0;
    m_prev = 0; m_cnt = 0; m_land = 1'b0;
    last_x = IX; last_y = IY;
  endfunction

  function automatic exp_t model_frame(input int s, input bit land_eff);
    exp_t e;
    bit   motion;
    motion = (s >= 1 && s <= 5) || (s >= 7 && s <= 9);
    e.done = 1'b0;
    if (s == 0) begin
      m_px = IX * 64; m_py = IY * 64; m_vx = 0; m_vy = 0;
    end else if (motion) begin
      if (s != m_prev || land_eff) begin
        case (s)
          1:       begin m_vx = 0;   m_vy = -256; end
          2:       begin m_vx = -64; m_vy = -256; end
          3:       begin m_vx = 64;  m_vy = -256; end
          4:       begin m_vx = 0;   m_vy = 0;    end
          5:       begin m_vx = 0;   m_vy = -384; end
          7:       begin m_vx = 64;  m_vy = -128; end
          8:       begin m_vx = -64; m_vy = -128; end
          default: begin m_vx = 0;   m_vy = 128;  end
        endcase
      end else begin
        m_vy = (m_vy + 8 > 512) ? 512 : m_vy + 8;
      end
      m_px += m_vx;
      m_py += m_vy;
      if (m_px < 0) begin m_px = 0; m_vx = 0; end
      else if (m_px > XMAXFP) begin m_px = XMAXFP; m_vx = 0; end
      if (m_py < 0) begin m_py = 0; m_vy = 0; end
      else if (m_py > YMAXFP) begin m_py = YMAXFP; m_vy = 0; end
    end else begin
      m_vx = 0; m_vy = 0;
    end
    if (s == 6) begin
      if (m_cnt < DIE) begin
        m_cnt++;
        e.done = (m_cnt == DIE);
      end
    end else begin
      m_cnt = 0;
    end
    m_prev = s;
    e.x = m_px / 64;
    e.y = m_py / 64;
    return e;
  endfunction

  // Monitor: after every edge, pop the frame result or check that outputs hold
  always @(posedge clk) begin
    bit   sof_s;
    exp_t e;
    sof_s = bus.startOfFrame;
    #1;
    if (!reset) begin
      if (sof_s) begin
        if (sb_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("topLeftX", int'(bus.topLeftX), e.x);
          chk("topLeftY", int'(bus.topLeftY), e.y);
          chk("die_done_frame", int'(bus.die_done), int'(e.done));
          last_x = e.x;
          last_y = e.y;
        end
      end else begin
        chk("hold_x", int'(bus.topLeftX), last_x);
        chk("hold_y", int'(bus.topLeftY), last_y);
        chk("die_done_idle", int'(bus.die_done), 0);
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    bus.startOfFrame = 1'b0;
    bus.bumpy_collision = 1'b0;
    #1;
    chk("rst_x", int'(bus.topLeftX), IX);
    chk("rst_y", int'(bus.topLeftY), IY);
    chk("rst_done", int'(bus.die_done), 0);
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_frame(input int s, input int gap, input bit land_mid, input bit land_sof);
    exp_t e;
    bit   lm;
    lm = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      bus.state = 4'(s);
      if (land_mid && i == gap / 2) begin
        bus.bumpy_collision = 1'b1;
        bus.HitEdgeCode = 4'b0001;
      end else begin
        bus.bumpy_collision = ($urandom_range(0, 3) == 0);
        bus.HitEdgeCode = 4'($urandom_range(2, 15));
      end
      if (bus.bumpy_collision && bus.HitEdgeCode == 4'b0001) lm = 1'b1;
    end
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    bus.state = 4'(s);
    bus.bumpy_collision = land_sof;
    bus.HitEdgeCode = land_sof ? 4'b0001 : 4'($urandom_range(2, 15));
    e = model_frame(s, lm | land_sof);
    sb_q.push_back(e);
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.bumpy_collision = 1'b0;
  endtask

  initial begin
    int s;
    reset = 1'b1;
    bus.startOfFrame = 1'b0;
    bus.state = 4'd0;
    bus.bumpy_collision = 1'b0;
    bus.HitEdgeCode = 4'd0;
    #1;
    chk("async_rst_x", int'(bus.topLeftX), IX);
    chk("async_rst_y", int'(bus.topLeftY), IY);
    chk("async_rst_done", int'(bus.die_done), 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_frame(0, 2, 1'b0, 1'b0);
    run_frame(3, 2, 1'b0, 1'b0);
    run_frame(3, 2, 1'b0, 1'b0);
    run_frame(2, 2, 1'b0, 1'b0);
    run_frame(2, 3, 1'b1, 1'b0);
    run_frame(2, 2, 1'b0, 1'b0);
    run_frame(2, 1, 1'b0, 1'b1);
    run_frame(3, 1, 1'b0, 1'b1);
    // Long walk left: reaches the left wall and falls to the floor
    for (int i = 0; i < 300; i++) run_frame(2, 1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) run_frame(6, 1, 1'b0, 1'b0);
    run_frame(1, 1, 1'b0, 1'b0);
    run_frame(6, 1, 1'b0, 1'b0);
    run_frame(6, 1, 1'b0, 1'b0);
    run_frame(1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) run_frame(6, 1, 1'b0, 1'b0);
    run_frame(6, 1, 1'b0, 1'b0);
    run_frame(6, 2, 1'b0, 1'b0);
    do_reset(2);
    for (int i = 0; i < 5; i++) run_frame(6, 1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) run_frame(5, 1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) run_frame(3, 1, 1'b0, 1'b0);

    s = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 30) begin
        s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                        : int'($urandom_range(1, 9));
      end
      if ($urandom_range(0, 199) == 0) do_reset(1);
      run_frame(s, $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
